arcade_input_conditioner: RTL and testbench

// - Parametrised input front end between raw cabinet/host controls and the blockade core's in_1/in_2/in_4 ports.
// - Synchronises and debounces every control bit, and stretches coin edges into fixed-width pulses.
// - Packs per-game-mode active-low input bytes, registered, for Blockade, Comotion and Hustle.
// - Replaces the ad-hoc per-mode case block in top levels; shared by the sim and MiSTer tops.

---
 rtl/arcade_input_pkg.sv | 41 ++++
 rtl/arcade_input_conditioner_if.sv | 26 ++
 rtl/input_debounce.sv | 42 ++++
 rtl/arcade_input_conditioner.sv | 151 +++++++++++++++
 tb/tb_arcade_input_conditioner.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arcade_input_pkg.sv
// Shared constants and types for the arcade input conditioner.
// Game-mode encodings, joystick direction indices and per-player helpers.
package arcade_input_pkg;

    localparam logic [1:0] GAME_BLOCKADE = 2'd0;
    localparam logic [1:0] GAME_COMOTION = 2'd1;
    localparam logic [1:0] GAME_HUSTLE   = 2'd2;

    localparam int DIR_RIGHT = 0;
    localparam int DIR_LEFT  = 1;
    localparam int DIR_DOWN  = 2;
    localparam int DIR_UP    = 3;

    typedef logic [3:0] joy4_t;

    typedef enum logic {
        COIN_IDLE,
        COIN_PULSE
    } coin_state_t;

    // Byte nibble order expected by the core: {left, down, right, up}.
    function automatic joy4_t pack_dir(input joy4_t j);
        return {j[DIR_LEFT], j[DIR_DOWN], j[DIR_RIGHT], j[DIR_UP]};
    endfunction

    // Opposing directions held together cancel to neutral.
    function automatic joy4_t socd_neutral(input joy4_t j);
        joy4_t r;
        r = j;
        if (j[DIR_LEFT] && j[DIR_RIGHT]) begin
            r[DIR_LEFT]  = 1'b0;
            r[DIR_RIGHT] = 1'b0;
        end
        if (j[DIR_UP] && j[DIR_DOWN]) begin
            r[DIR_UP]   = 1'b0;
            r[DIR_DOWN] = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/arcade_input_conditioner_if.sv
// Control-side bundle: raw cabinet/host controls in, packed core bytes out.
// master = control source / byte consumer, slave = the conditioner.
interface arcade_input_conditioner_if #(
    parameter int NUM_PLAYERS = 4
);
    logic [1:0]               game_mode;
    logic [4*NUM_PLAYERS-1:0] joy;
    logic                     btn_coin;
    logic [1:0]               btn_start;
    logic                     btn_boom;
    logic [15:0]              dip_sw;
    logic [7:0]               in_1;
    logic [7:0]               in_2;
    logic [7:0]               in_4;
    logic                     coin_pulse;

    modport master (
        output game_mode, joy, btn_coin, btn_start, btn_boom, dip_sw,
        input  in_1, in_2, in_4, coin_pulse
    );

    modport slave (
        input  game_mode, joy, btn_coin, btn_start, btn_boom, dip_sw,
        output in_1, in_2, in_4, coin_pulse
    );
endinterface

// File: rtl/input_debounce.sv
// Purpose: single-bit debouncer; output follows input after DEBOUNCE_CYCLES stable cycles (0 = pass-through).
// Latency: DEBOUNCE_CYCLES cycles from a stable input change; combinational when DEBOUNCE_CYCLES=0.
// Backpressure: none, free-running level filter.
module input_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic din,
    output logic dout
);
    localparam logic [15:0] CNT_LAST = (DEBOUNCE_CYCLES == 0) ? 16'd0
                                                               : 16'(DEBOUNCE_CYCLES - 1);

    logic [15:0] cnt_q, cnt_d;
    logic        state_q, state_d;

    always_comb begin
        cnt_d   = '0;
        state_d = state_q;
        if (din != state_q) begin
            if (cnt_q == CNT_LAST) begin
                state_d = ~state_q;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cnt_q   <= '0;
            state_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign dout = (DEBOUNCE_CYCLES == 0) ? din : state_q;

endmodule

// File: rtl/arcade_input_conditioner.sv
// Purpose: sync + debounce controls, stretch coin, pack per-mode active-low bytes; ARCADE_INPUT_SOCD_EN adds neutral SOCD.
// Latency: raw edge to bytes = 2 + DEBOUNCE_CYCLES + 1 cycles; coin_pulse aligned with in_1[7].
// Backpressure: none; level outputs are re-registered every cycle.
module arcade_input_conditioner
    import arcade_input_pkg::*;
#(
    parameter int NUM_PLAYERS       = 4,
    parameter int DEBOUNCE_CYCLES   = 16,
    parameter int COIN_PULSE_CYCLES = 4096
) (
    input  logic                        clk_sys,
    input  logic                        reset,
    arcade_input_conditioner_if.slave   io
);
    localparam int          NJ         = 4 * NUM_PLAYERS;
    localparam int          NB         = NJ + 4;
    localparam logic [31:0] PULSE_LAST = 32'(COIN_PULSE_CYCLES - 1);

    logic [NB-1:0] raw, sync1_q, sync1_d, sync2_q, sync2_d, db;
    logic [15:0]   joy_pad;
    logic          db_coin, db_boom;
    logic [1:0]    db_start;
    joy4_t         pl [4];
    joy4_t         p1, p2, p3, p4;

    coin_state_t   coin_state_q, coin_state_d;
    logic [31:0]   coin_cnt_q, coin_cnt_d;
    logic          coin_prev_q, coin_prev_d;
    logic [1:0]    mode_q, mode_d;
    logic          pulse_next;
    logic [7:0]    in_1_q, in_1_d, in_2_q, in_2_d, in_4_q, in_4_d;
    logic          unused_dip;

    assign raw        = {io.btn_boom, io.btn_start, io.btn_coin, io.joy};
    assign unused_dip = ^io.dip_sw[7:3];

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
    end

    for (genvar i = 0; i < NB; i++) begin : g_db
        input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk_sys (clk_sys),
            .reset   (reset),
            .din     (sync2_q[i]),
            .dout    (db[i])
        );
    end

    assign db_coin  = db[NJ];
    assign db_start = db[NJ+2:NJ+1];
    assign db_boom  = db[NJ+3];
    // Absent players are zero-padded so they read as released.
    assign joy_pad  = 16'(db[NJ-1:0]);

    always_comb begin
        for (int p = 0; p < 4; p++) begin
`ifdef ARCADE_INPUT_SOCD_EN
            pl[p] = socd_neutral(joy_pad[4*p +: 4]);
`else
            pl[p] = joy_pad[4*p +: 4];
`endif
        end
        p1 = pack_dir(pl[0]);
        p2 = pack_dir(pl[1]);
        p3 = pack_dir(pl[2]);
        p4 = pack_dir(pl[3]);
    end

    always_comb begin
        coin_state_d = coin_state_q;
        coin_cnt_d   = coin_cnt_q;
        coin_prev_d  = db_coin;
        mode_d       = io.game_mode;
        case (coin_state_q)
            COIN_IDLE: begin
                if (db_coin && !coin_prev_q) begin
                    coin_state_d = COIN_PULSE;
                    coin_cnt_d   = PULSE_LAST;
                end
            end
            COIN_PULSE: begin
                if (coin_cnt_q == '0) begin
                    coin_state_d = COIN_IDLE;
                end else begin
                    coin_cnt_d = coin_cnt_q - 32'd1;
                end
            end
        endcase
        // A mode switch drops any pulse in flight rather than carrying it into the new game.
        if (io.game_mode != mode_q) begin
            coin_state_d = COIN_IDLE;
            coin_cnt_d   = '0;
        end
        pulse_next = (coin_state_d == COIN_PULSE);
    end

    always_comb begin
        in_1_d = 8'hFF;
        in_2_d = 8'hFF;
        in_4_d = 8'hFF;
        case (mode_q)
            GAME_BLOCKADE: begin
                in_1_d = ~{pulse_next, io.dip_sw[2:0], 1'b0, db_boom, 2'b00};
                in_2_d = ~{p1, p2};
            end
            GAME_COMOTION: begin
                in_1_d = ~{pulse_next, 2'b00, db_start[0] | db_start[1], io.dip_sw[0], db_boom, 2'b00};
                in_2_d = ~{p2, p1};
                in_4_d = ~{p4, p3};
            end
            GAME_HUSTLE: begin
                in_1_d = ~{pulse_next, 2'b00, db_start[1], db_start[0], io.dip_sw[2:0]};
                in_2_d = ~{p1, p2};
                in_4_d = io.dip_sw[15:8];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            coin_state_q <= COIN_IDLE;
            coin_cnt_q   <= '0;
            coin_prev_q  <= 1'b0;
            mode_q       <= GAME_BLOCKADE;
            in_1_q       <= 8'hFF;
            in_2_q       <= 8'hFF;
            in_4_q       <= 8'hFF;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            coin_state_q <= coin_state_d;
            coin_cnt_q   <= coin_cnt_d;
            coin_prev_q  <= coin_prev_d;
            mode_q       <= mode_d;
            in_1_q       <= in_1_d;
            in_2_q       <= in_2_d;
            in_4_q       <= in_4_d;
        end
    end

    assign io.in_1       = in_1_q;
    assign io.in_2       = in_2_q;
    assign io.in_4       = in_4_q;
    assign io.coin_pulse = (coin_state_q == COIN_PULSE);

endmodule

// File: tb/tb_arcade_input_conditioner.sv
// Bench for arcade_input_conditioner: main instance (4 players, 16-cycle debounce, 8-cycle coin)
// plus a bypass instance (1 player, no debounce) for short-latency and coin re-edge cases.
`timescale 1ns/1ps
module tb_arcade_input_conditioner;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    arcade_input_conditioner_if #(.NUM_PLAYERS(4)) bus  ();
    arcade_input_conditioner_if #(.NUM_PLAYERS(1)) bus0 ();

    arcade_input_conditioner #(.NUM_PLAYERS(4), .DEBOUNCE_CYCLES(16), .COIN_PULSE_CYCLES(8)) dut (
        .clk_sys (clk),
        .reset   (reset),
        .io      (bus.slave)
    );

    arcade_input_conditioner #(.NUM_PLAYERS(1), .DEBOUNCE_CYCLES(0), .COIN_PULSE_CYCLES(8)) dut0 (
        .clk_sys (clk),
        .reset   (reset),
        .io      (bus0.slave)
    );

    // Snapshot layout: [24]=coin_pulse [23:16]=in_1 [15:8]=in_2 [7:0]=in_4
    localparam logic [24:0] M_ALL  = 25'h1FFFFFF;
    localparam logic [24:0] M_COIN = 25'h1000000;
    localparam logic [24:0] M_IN1  = 25'h0FF0000;
    localparam logic [24:0] M_IN2  = 25'h000FF00;
    localparam logic [24:0] M_IN4  = 25'h00000FF;

    typedef struct {
        string       tag;
        logic [24:0] val;
        logic [24:0] mask;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [24:0] snap();
        return {bus.coin_pulse, bus.in_1, bus.in_2, bus.in_4};
    endfunction

    function automatic logic [24:0] snap0();
        return {bus0.coin_pulse, bus0.in_1, bus0.in_2, bus0.in_4};
    endfunction

    task automatic push_exp(input string tag, input logic [24:0] val, input logic [24:0] mask);
        exp_t e;
        e.tag  = tag;
        e.val  = val;
        e.mask = mask;
        exp_q.push_back(e);
    endtask

    task automatic idle_inputs();
        bus.game_mode  = 2'd0; bus.joy  = '0; bus.btn_coin  = 1'b0; bus.btn_start  = 2'b00;
        bus.btn_boom   = 1'b0; bus.dip_sw  = 16'h0000;
        bus0.game_mode = 2'd0; bus0.joy = '0; bus0.btn_coin = 1'b0; bus0.btn_start = 2'b00;
        bus0.btn_boom  = 1'b0; bus0.dip_sw = 16'h0000;
    endtask

    task automatic wait_pulse(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            if (bus.coin_pulse === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        exp_t e; logic [24:0] obs;
        idle_inputs();
        reset = 1'b1;
        push_exp("reset_hold", {1'b0, 8'hFF, 8'hFF, 8'hFF}, M_ALL);
        tick(3);
        e = exp_q.pop_front(); obs = snap(); n_checks++;
        if ((obs & e.mask) !== (e.val & e.mask)) begin
            n_fail++; $display("FAIL %s: observed %h required %h", e.tag, obs & e.mask, e.val & e.mask);
        end
        reset = 1'b0;
        push_exp("reset_idle", {1'b0, 8'hFF, 8'hFF, 8'hFF}, M_ALL);
        tick(25);
        e = exp_q.pop_front(); obs = snap(); n_checks++;
        if ((obs & e.mask) !== (e.val & e.mask)) begin
            n_fail++; $display("FAIL %s: observed %h required %h", e.tag, obs & e.mask, e.val & e.mask);
        end
    endtask

    task automatic test_debounce_glitch();
        exp_t e; logic [24:0] obs;
        bus.joy[0] = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (c == 10) bus.joy[0] = 1'b0;
            push_exp("glitch_in2", {1'b0, 8'hFF, 8'hFF, 8'hFF}, M_IN2);
            tick(1);
            e = exp_q.pop_front(); obs = snap(); n_checks++;
            if ((obs & e.mask) !== (e.val & e.mask)) begin
                n_fail++; $display("FAIL %s: cycle %0d observed %h required %h", e.tag, c, obs & e.mask, e.val & e.mask);
            end
        end
    endtask

    task automatic test_debounce_latency();
        exp_t e; logic [24:0] obs;
        bus.joy[0] = 1'b1;  // P1 right lands on in_2[5] in BLOCKADE
        push_exp("latency_18", {1'b0, 8'hFF, 8'hFF, 8'hFF}, M_IN2);
        push_exp("latency_19", {1'b0, 8'hFF, 8'hDF, 8'hFF}, M_IN2);
        tick(18);
        e = exp_q.pop_front(); obs = snap(); n_checks++;
        if ((obs & e.mask) !== (e.val & e.mask)) begin
            n_fail++; $display("FAIL %s: observed %h required %h", e.tag, obs & e.mask, e.val & e.mask);
        end
        tick(1);
        e = exp_q.pop_front(); obs = snap(); n_checks++;
        if ((obs & e.mask) !== (e.val & e.mask)) begin
            n_fail++; $display("FAIL %s: observed %h required %h", e.tag, obs & e.mask, e.val & e.mask);
        end
        bus.joy[0] = 1'b0;
        tick(25);
    endtask

    task automatic test_coin_stretch();
        int width = 0, pulses = 0, misalign = 0;
        logic prev = 1'b0;
        bus.btn_coin = 1'b1;
        for (int c = 0; c < 130; c++) begin
            if (c == 100) bus.btn_coin = 1'b0;
            tick(1);
            if (bus.coin_pulse === 1'b1) width++;
            if (bus.coin_pulse === 1'b1 && prev === 1'b0) pulses++;
            if (bus.in_1[7] !== ~bus.coin_pulse) misalign++;
            prev = bus.coin_pulse;
        end
        n_checks++;
        if (pulses !== 1) begin n_fail++; $display("FAIL coin_count: observed %0d pulses required 1", pulses); end
        n_checks++;
        if (width !== 8) begin n_fail++; $display("FAIL coin_width: observed %0d cycles required 8", width); end
        n_checks++;
        if (misalign !== 0) begin n_fail++; $display("FAIL coin_in1_bit7: observed %0d misaligned cycles required 0", misalign); end
    endtask

    task automatic test_bypass();
        exp_t e; logic [24:0] obs;
        int width = 0, pulses = 0;
        logic prev = 1'b0;
        bus0.joy[0] = 1'b1;
        push_exp("bypass_2", {1'b0, 8'hFF, 8'hFF, 8'hFF}, M_IN2);
        push_exp("bypass_3", {1'b0, 8'hFF, 8'hDF, 8'hFF}, M_IN2);
        tick(2);
        e = exp_q.pop_front(); obs = snap0(); n_checks++;
        if ((obs & e.mask) !== (e.val & e.mask)) begin
            n_fail++; $display("FAIL %s: observed %h required %h", e.tag, obs & e.mask, e.val & e.mask);
        end
        tick(1);
        e = exp_q.pop_front(); obs = snap0(); n_checks++;
        if ((obs & e.mask) !== (e.val & e.mask)) begin
            n_fail++; $display("FAIL %s: observed %h required %h", e.tag, obs & e.mask, e.val & e.mask);
        end
        bus0.joy[0] = 1'b0;
        tick(5);
        // Two coin edges four cycles apart: the second arrives mid-pulse and must be dropped.
        for (int c = 0; c < 40; c++) begin
            bus0.btn_coin = (c < 2) || (c >= 4 && c < 6);
            tick(1);
            if (bus0.coin_pulse === 1'b1) width++;
            if (bus0.coin_pulse === 1'b1 && prev === 1'b0) pulses++;
            prev = bus0.coin_pulse;
        end
        n_checks++;
        if (pulses !== 1) begin n_fail++; $display("FAIL coin_reedge_count: observed %0d pulses required 1", pulses); end
        n_checks++;
        if (width !== 8) begin n_fail++; $display("FAIL coin_reedge_width: observed %0d cycles required 8", width); end
    endtask

    task automatic test_modes();
        exp_t e; logic [24:0] obs;
        bus.game_mode = 2'd1; bus.joy[3] = 1'b1; bus.joy[12] = 1'b1; bus.btn_start = 2'b10;
        push_exp("comotion", {1'b0, 8'hEF, 8'hFE, 8'hDF}, M_IN1 | M_IN2 | M_IN4);
        tick(25);
        e = exp_q.pop_front(); obs = snap(); n_checks++;
        if ((obs & e.mask) !== (e.val & e.mask)) begin
            n_fail++; $display("FAIL %s: observed %h required %h", e.tag, obs & e.mask, e.val & e.mask);
        end
        bus.game_mode = 2'd2; bus.joy = '0; bus.btn_start = 2'b01; bus.dip_sw = 16'hD100;
        push_exp("hustle", {1'b0, 8'hF7, 8'hFF, 8'hD1}, M_IN1 | M_IN2 | M_IN4);
        tick(25);
        e = exp_q.pop_front(); obs = snap(); n_checks++;
        if ((obs & e.mask) !== (e.val & e.mask)) begin
            n_fail++; $display("FAIL %s: observed %h required %h", e.tag, obs & e.mask, e.val & e.mask);
        end
        bus.game_mode = 2'd0; bus.btn_start = 2'b00; bus.dip_sw = 16'h0005; bus.btn_boom = 1'b1; bus.joy[6] = 1'b1;
        push_exp("blockade", {1'b0, 8'hAB, 8'hFB, 8'hFF}, M_IN1 | M_IN2 | M_IN4);
        tick(25);
        e = exp_q.pop_front(); obs = snap(); n_checks++;
        if ((obs & e.mask) !== (e.val & e.mask)) begin
            n_fail++; $display("FAIL %s: observed %h required %h", e.tag, obs & e.mask, e.val & e.mask);
        end
        bus.game_mode = 2'd3;
        push_exp("mode3", {1'b0, 8'hFF, 8'hFF, 8'hFF}, M_IN1 | M_IN2 | M_IN4);
        tick(3);
        e = exp_q.pop_front(); obs = snap(); n_checks++;
        if ((obs & e.mask) !== (e.val & e.mask)) begin
            n_fail++; $display("FAIL %s: observed %h required %h", e.tag, obs & e.mask, e.val & e.mask);
        end
        idle_inputs();
        tick(25);
    endtask

    task automatic test_mode_abort();
        exp_t e; logic [24:0] obs;
        bit ok;
        int late = 0;
        bus.dip_sw = 16'hD100; bus.btn_coin = 1'b1;
        wait_pulse(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL abort_wait: coin_pulse observed 0 required 1 within 60 cycles"); end
        tick(2);
        bus.game_mode = 2'd2;
        push_exp("abort_coin", {1'b0, 8'hFF, 8'h00, 8'hFF}, M_COIN | M_IN1 | M_IN4);
        push_exp("abort_repack", {1'b0, 8'h00, 8'h00, 8'hD1}, M_COIN | M_IN4);
        tick(1);
        e = exp_q.pop_front(); obs = snap(); n_checks++;
        if ((obs & e.mask) !== (e.val & e.mask)) begin
            n_fail++; $display("FAIL %s: observed %h required %h", e.tag, obs & e.mask, e.val & e.mask);
        end
        tick(1);
        e = exp_q.pop_front(); obs = snap(); n_checks++;
        if ((obs & e.mask) !== (e.val & e.mask)) begin
            n_fail++; $display("FAIL %s: observed %h required %h", e.tag, obs & e.mask, e.val & e.mask);
        end
        for (int c = 0; c < 20; c++) begin
            tick(1);
            if (bus.coin_pulse !== 1'b0) late++;
        end
        n_checks++;
        if (late !== 0) begin n_fail++; $display("FAIL abort_no_restart: observed %0d pulse cycles required 0", late); end
        idle_inputs();
        tick(25);
    endtask

    task automatic test_reset_mid();
        exp_t e; logic [24:0] obs;
        bit ok;
        int noisy = 0;
        bus.btn_coin = 1'b1;
        wait_pulse(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL reset_wait: coin_pulse observed 0 required 1 within 60 cycles"); end
        tick(2);
        reset = 1'b1; bus.btn_coin = 1'b0;
        push_exp("reset_mid_pulse", {1'b0, 8'hFF, 8'hFF, 8'hFF}, M_ALL);
        tick(1);
        e = exp_q.pop_front(); obs = snap(); n_checks++;
        if ((obs & e.mask) !== (e.val & e.mask)) begin
            n_fail++; $display("FAIL %s: observed %h required %h", e.tag, obs & e.mask, e.val & e.mask);
        end
        reset = 1'b0;
        bus.joy[1] = 1'b1;
        tick(8);
        reset = 1'b1; bus.joy[1] = 1'b0;
        tick(2);
        reset = 1'b0;
        for (int c = 0; c < 30; c++) begin
            tick(1);
            if (snap() !== {1'b0, 8'hFF, 8'hFF, 8'hFF}) noisy++;
        end
        n_checks++;
        if (noisy !== 0) begin n_fail++; $display("FAIL reset_mid_debounce: observed %0d non-idle cycles required 0", noisy); end
    endtask

    task automatic test_socd();
        exp_t e; logic [24:0] obs;
        logic [7:0] lr_exp, all_exp;
`ifdef ARCADE_INPUT_SOCD_EN
        lr_exp  = 8'hFF;
        all_exp = 8'hFF;
`else
        lr_exp  = 8'h5F;
        all_exp = 8'h0F;
`endif
        bus.joy[0] = 1'b1; bus.joy[1] = 1'b1;
        push_exp("socd_left_right", {1'b0, 8'hFF, lr_exp, 8'hFF}, M_IN2);
        tick(25);
        e = exp_q.pop_front(); obs = snap(); n_checks++;
        if ((obs & e.mask) !== (e.val & e.mask)) begin
            n_fail++; $display("FAIL %s: observed %h required %h", e.tag, obs & e.mask, e.val & e.mask);
        end
        bus.joy[3:0] = 4'hF;
        push_exp("socd_all_four", {1'b0, 8'hFF, all_exp, 8'hFF}, M_IN2);
        tick(25);
        e = exp_q.pop_front(); obs = snap(); n_checks++;
        if ((obs & e.mask) !== (e.val & e.mask)) begin
            n_fail++; $display("FAIL %s: observed %h required %h", e.tag, obs & e.mask, e.val & e.mask);
        end
        idle_inputs();
        tick(25);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at 1 ms, required completion");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        test_reset();
        test_debounce_glitch();
        test_debounce_latency();
        test_coin_stretch();
        test_bypass();
        test_modes();
        test_mode_abort();
        test_reset_mid();
        test_socd();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
